// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem responder: FSM state, parameter defaults
// and the list of byte-enable patterns legal under DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH_WORDS_DEF = 256;
  localparam int WAIT_CYCLES_DEF = 1;

  // Naturally aligned byte, halfword and word lanes, plus the empty pattern.
  localparam int N_LEGAL_BE = 8;
  localparam logic [3:0] LEGAL_BE [N_LEGAL_BE] = '{
    4'b0000, 4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_BE; i++) begin
      if (be == LEGAL_BE[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous byte-lane write, registered read, one access per enable.
// Contents are never reset; rdata holds its value between read accesses.
module dmem_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     be,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready memory responder: accept in IDLE, WAIT_CYCLES wait states, hold response in RESP until rsp_ready.
// Optional DMEM_ALIGN_CHECK_EN rejects byte-enable patterns that are not naturally aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_go;
  logic        range_err;
  logic        be_err;
  logic        acc_err;

  logic        err_q;
  logic        rd_ok_q;
  logic [31:0] arr_rdata;
  logic [1:0]  unused_addr_lsb;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

  // With zero wait states the access happens on the acceptance edge, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_be    = cap_be;
    end
  end

  assign acc_go          = (state != RESP) && (state_nxt == RESP);
  assign range_err       = |acc_addr[31:AW+2];
  assign unused_addr_lsb = acc_addr[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign be_err = !be_legal(acc_be);
`else
  assign be_err = 1'b0;
`endif

  assign acc_err = range_err | be_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (acc_go),
    .we    (acc_we & ~acc_err),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else if (acc_go) begin
      err_q   <= acc_err;
      rd_ok_q <= ~acc_we & ~acc_err;
    end else if (state == RESP && rsp_ready) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = rd_ok_q ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters (DEPTH_WORDS=256, WAIT_CYCLES=1).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lat counts edges from the acceptance edge (counted as 1) until rsp_valid is seen.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int latency);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    latency = 1;
    while (!rsp_valid && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", rsp_valid, 1'b0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst_rdy", req_ready, 1'b1);

    // Basic write then read, both with WAIT_CYCLES+1 = 2 edges of latency.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr10_lat", lat, 2);
    chk("wr10_err", er, 1'b0);
    chk("wr10_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd10_lat", lat, 2);
    chk("rd10_rdata", rd, 32'hDEADBEEF);
    chk("rd10_err", er, 1'b0);

    // Partial lane write merges into the existing word; low address bits ignored.
    xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    xact(1'b1, 32'h20, 32'h000000AA, 4'h1, rd, er, lat);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("rd20_rdata", rd, 32'h112233AA);
    xact(1'b0, 32'h23, 32'h0, 4'h0, rd, er, lat);
    chk("rd23_rdata", rd, 32'h112233AA);

    // Out-of-range access: error, zero data, no aliasing onto word 0.
    xact(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
    xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("wr400_err", er, 1'b1);
    xact(1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat);
    chk("rd400_err", er, 1'b1);
    chk("rd400_rdata", rd, 32'h0);
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("rd0_rdata", rd, 32'h0BADF00D);
    chk("rd0_err", er, 1'b0);

    // Backpressure: hold RESP five cycles with a competing write request.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h55555555; req_be = 4'hF;
      @(posedge clk); #1;
      chk("stall_vld", rsp_valid, 1'b1);
      chk("stall_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("stall_err", rsp_err, 1'b0);
      chk("stall_rdy", req_ready, 1'b0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall_done_vld", rsp_valid, 1'b0);
    chk("stall_done_rdy", req_ready, 1'b1);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("stall_nowrite", rd, 32'hDEADBEEF);

    // Reset while a write sits in WAIT: aborted, storage keeps the old value.
    xact(1'b1, 32'h30, 32'h12345678, 4'hF, rd, er, lat);
    xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEBABE; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_wait", req_ready, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    chk("abort_vld", rsp_valid, 1'b0);
    chk("abort_err", rsp_err, 1'b0);
    chk("abort_rdata", rsp_rdata, 32'h0);
    chk("abort_rdy", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("abort_old", rd, 32'h12345678);

    // Empty byte-enable is a clean no-op.
    xact(1'b1, 32'h40, 32'h11111111, 4'hF, rd, er, lat);
    xact(1'b1, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("be0_err", er, 1'b0);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("be0_rdata", rd, 32'h11111111);

    // Unaligned lane pattern 0101.
    xact(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("be5_err", er, 1'b1);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("be5_rdata", rd, 32'h11111111);
`else
    chk("be5_err", er, 1'b0);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk("be5_rdata", rd, 32'h11BB11DD);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit storage words, power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: number of extra wait cycles between request acceptance and response, range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  byte-lane enables; bit i enables bits 8i+7:8i.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and for errors.
REQ-014 rsp_err  output  1  request was rejected.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 IDLE: req_ready=1; if req_valid=1, capture we/addr/wdata/be, then go to WAIT when WAIT_CYCLES>0, otherwise to RESP.
REQ-017 WAIT: req_ready=0; a 4-bit counter is loaded with WAIT_CYCLES-1 on entry and decrements each cycle; when it reaches 0, go to RESP.
REQ-018 The memory access (read sample or byte-lane write) SHALL occur on the edge that enters RESP; rsp_rdata and rsp_err are registered on that same edge.
REQ-019 RESP: rsp_valid=1 and req_ready=0; outputs are held stable until rsp_ready=1, then return to IDLE; rsp_valid deasserts on that edge.
REQ-020 Latency: a request accepted at edge N gives rsp_valid=1 after edge N+WAIT_CYCLES+1.
REQ-021 Throughput: at most one request per WAIT_CYCLES+2 cycles; a new request is accepted no earlier than the cycle after the response handshake.
REQ-022 Word index is req_addr[log2(DEPTH_WORDS)+1:2]; req_addr[1:0] is ignored for indexing.
REQ-023 If req_addr >= 4*DEPTH_WORDS: rsp_err=1, rsp_rdata=0, no write.
REQ-024 Write: only enabled lanes are updated; be=0000 is a no-op with rsp_err=0.
REQ-025 Read: returns the full word; the initiator performs lane selection.
REQ-026 req_valid while req_ready=0 SHALL be ignored and cause no side effects.
REQ-027 Inputs other than req_valid are don't-care outside the IDLE acceptance cycle.

Reset
REQ-028 rst_n=1 SHALL immediately force: state IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, and req_ready=1 after release.
REQ-029 Reset during WAIT or RESP SHALL abort the transaction; a write not yet committed (WAIT) SHALL NOT occur.
REQ-030 Storage contents SHALL NOT be reset.

Configuration
REQ-031 With DMEM_ALIGN_CHECK_EN defined, be must be one of 0000, 0001, 0010, 0100, 1000, 0011, 1100 or 1111; any other pattern gives rsp_err=1, no write, rsp_rdata=0.
REQ-032 Without DMEM_ALIGN_CHECK_EN, any be pattern is accepted; only the range check of REQ-023 produces errors.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the FSM state enum, the DEPTH_WORDS and WAIT_CYCLES defaults, and the legal-be constant list.
REQ-034 Storage SHALL be a sub-module dmem_array (single port, synchronous byte-lane write, registered read); the FSM and checks live in dmem_responder.

Verification
REQ-035 WAIT_CYCLES=1, write addr 0x10, data 0xDEADBEEF, be=1111, then read 0x10 -> each rsp_valid arrives 2 edges after acceptance; read rdata=0xDEADBEEF, err=0.
REQ-036 Write 0x11223344 to addr 0x20 with be=1111, then 0xAA with be=0001, then read -> rdata=0x112233AA.
REQ-037 DEPTH_WORDS=256, read addr 0x400 -> rsp_err=1, rdata=0; a prior write to 0x400 leaves word 0 unchanged.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready=0, a concurrent req_valid is ignored; rsp_ready=1 -> IDLE next edge.
REQ-039 Assert reset during WAIT of a write to 0x30 -> outputs 0 immediately; a later read of 0x30 returns its old value.
REQ-040 With DMEM_ALIGN_CHECK_EN, write with be=0101 -> err=1, no write; without the macro -> err=0, lanes 0 and 2 written.
